// File: rtl/i2c_target_mem.sv
// I2C target with a pointer-addressed byte memory and committed-write monitor strobes.
// Define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample majority filter on SCL/SDA.
module i2c_target_mem #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h22,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       busy_o,
  output logic       start_det_o,
  output logic       stop_det_o,
  output logic       wr_strobe_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o
);
  localparam int unsigned PTR_W = $clog2(MEM_DEPTH);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK, S_WAIT
  } state_t;

  logic r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
  logic r_scl_d, r_sda_d;
  logic w_scl, w_sda;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
    end else begin
      r_scl_s1 <= scl_i;
      r_scl_s2 <= r_scl_s1;
      r_sda_s1 <= sda_i;
      r_sda_s2 <= r_sda_s1;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic r_scl_m1, r_scl_m2, r_sda_m1, r_sda_m2, r_scl_f, r_sda_f;

  // Majority of the last three synchronized samples; a lone outlier never propagates.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_scl_m1 <= 1'b1;
      r_scl_m2 <= 1'b1;
      r_sda_m1 <= 1'b1;
      r_sda_m2 <= 1'b1;
      r_scl_f  <= 1'b1;
      r_sda_f  <= 1'b1;
    end else begin
      r_scl_m1 <= r_scl_s2;
      r_scl_m2 <= r_scl_m1;
      r_sda_m1 <= r_sda_s2;
      r_sda_m2 <= r_sda_m1;
      r_scl_f  <= (r_scl_s2 & r_scl_m1) | (r_scl_s2 & r_scl_m2) | (r_scl_m1 & r_scl_m2);
      r_sda_f  <= (r_sda_s2 & r_sda_m1) | (r_sda_s2 & r_sda_m2) | (r_sda_m1 & r_sda_m2);
    end
  end

  assign w_scl = r_scl_f;
  assign w_sda = r_sda_f;
`else
  assign w_scl = r_scl_s2;
  assign w_sda = r_sda_s2;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  // SDA moving while SCL is steady high is a bus condition; simultaneous moves are data.
  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & ~w_sda & r_sda_d;
  assign w_stop     = w_scl & r_scl_d & w_sda & ~r_sda_d;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [7:0]         r_shift, w_shift_nxt;
  logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
  logic               r_rw, w_rw_nxt;
  logic               r_drive_low, w_drive_low_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_wr_strobe, w_wr_strobe_nxt;
  logic [7:0]         r_wr_addr, w_wr_addr_nxt;
  logic [7:0]         r_wr_data, w_wr_data_nxt;
  logic               r_sda_o, r_start_det, r_stop_det;
  logic               w_mem_we;
  logic [7:0]         w_mem_rd;
  logic [7:0]         r_mem [MEM_DEPTH];

  assign w_mem_rd = r_mem[r_ptr];

  always_ff @(posedge clk_i) begin
    if (w_mem_we) r_mem[r_ptr] <= r_shift;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_ptr       <= '0;
      r_rw        <= 1'b0;
      r_drive_low <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_sda_o     <= 1'b1;
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_ptr       <= w_ptr_nxt;
      r_rw        <= w_rw_nxt;
      r_drive_low <= w_drive_low_nxt;
      r_busy      <= w_busy_nxt;
      r_wr_strobe <= w_wr_strobe_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_sda_o     <= ~r_drive_low;
      r_start_det <= w_start;
      r_stop_det  <= w_stop;
    end
  end

  // Bits shift in on SCL rise; every SDA drive decision is taken on SCL fall.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_shift_nxt     = r_shift;
    w_ptr_nxt       = r_ptr;
    w_rw_nxt        = r_rw;
    w_drive_low_nxt = r_drive_low;
    w_busy_nxt      = r_busy;
    w_wr_strobe_nxt = 1'b0;
    w_wr_addr_nxt   = r_wr_addr;
    w_wr_data_nxt   = r_wr_data;
    w_mem_we        = 1'b0;
    if (w_stop) begin
      w_state_nxt     = S_IDLE;
      w_drive_low_nxt = 1'b0;
      w_busy_nxt      = 1'b0;
    end else if (w_start) begin
      w_state_nxt     = S_ADDR;
      w_cnt_nxt       = '0;
      w_drive_low_nxt = 1'b0;
    end else begin
      unique case (r_state)
        S_ADDR, S_PTR, S_WDATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = {r_shift[6:0], w_sda};
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end else if (w_scl_fall && r_cnt == CNT_W'(8)) begin
            w_drive_low_nxt = 1'b1;
            if (r_state == S_ADDR) begin
              if (r_shift[7:1] == SLAVE_ADDR) begin
                w_state_nxt = S_ADDR_ACK;
                w_rw_nxt    = r_shift[0];
                w_busy_nxt  = 1'b1;
              end else begin
                w_state_nxt     = S_WAIT;
                w_drive_low_nxt = 1'b0;
              end
            end else if (r_state == S_PTR) begin
              w_state_nxt = S_PTR_ACK;
              w_ptr_nxt   = PTR_W'(r_shift);
            end else begin
              w_state_nxt     = S_WDATA_ACK;
              w_mem_we        = 1'b1;
              w_wr_strobe_nxt = 1'b1;
              w_wr_addr_nxt   = 8'(r_ptr);
              w_wr_data_nxt   = r_shift;
              w_ptr_nxt       = r_ptr + PTR_W'(1);
            end
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            w_cnt_nxt = '0;
            if (r_rw) begin
              w_state_nxt     = S_RDATA;
              w_shift_nxt     = w_mem_rd;
              w_drive_low_nxt = ~w_mem_rd[7];
            end else begin
              w_state_nxt     = S_PTR;
              w_drive_low_nxt = 1'b0;
            end
          end
        end
        S_PTR_ACK, S_WDATA_ACK: begin
          if (w_scl_fall) begin
            w_state_nxt     = S_WDATA;
            w_cnt_nxt       = '0;
            w_drive_low_nxt = 1'b0;
          end
        end
        S_RDATA: begin
          if (w_scl_rise) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end else if (w_scl_fall) begin
            if (r_cnt == CNT_W'(8)) begin
              w_state_nxt     = S_RACK;
              w_drive_low_nxt = 1'b0;
            end else begin
              w_shift_nxt     = {r_shift[6:0], 1'b0};
              w_drive_low_nxt = ~r_shift[6];
            end
          end
        end
        S_RACK: begin
          if (w_scl_rise) begin
            w_ptr_nxt = r_ptr + PTR_W'(1);
            if (w_sda) begin
              w_state_nxt = S_WAIT;
              w_busy_nxt  = 1'b0;
            end
          end else if (w_scl_fall) begin
            w_state_nxt     = S_RDATA;
            w_cnt_nxt       = '0;
            w_shift_nxt     = w_mem_rd;
            w_drive_low_nxt = ~w_mem_rd[7];
          end
        end
        S_IDLE, S_WAIT: ;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign sda_o       = r_sda_o;
  assign busy_o      = r_busy;
  assign start_det_o = r_start_det;
  assign stop_det_o  = r_stop_det;
  assign wr_strobe_o = r_wr_strobe;
  assign wr_addr_o   = r_wr_addr;
  assign wr_data_o   = r_wr_data;

endmodule

// File: tb/tb_i2c_target_mem.sv
// Bench for i2c_target_mem: bit-level I2C master, array/pointer reference model, write monitor.
module tb_i2c_target_mem;
  localparam int H = 12;
  localparam int Q = 3;
  localparam logic [6:0] SLV = 7'h22;

  logic clk = 1'b0;
  logic rst, scl_m, sda_m;
  logic sda_bus;
  logic sda_o, busy_o, start_det_o, stop_det_o, wr_strobe_o;
  logic [7:0] wr_addr_o, wr_data_o;

  always #5 clk = ~clk;
  assign sda_bus = sda_m & sda_o;

  i2c_target_mem dut (
    .clk_i(clk), .rst_i(rst), .scl_i(scl_m), .sda_i(sda_bus),
    .sda_o(sda_o), .busy_o(busy_o), .start_det_o(start_det_o), .stop_det_o(stop_det_o),
    .wr_strobe_o(wr_strobe_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0]  mem_m [256];
  int          ptr_m = 0;
  logic [15:0] exp_q [$];
  logic [15:0] mon_q [$];
  logic [7:0]  wbuf [8];
  int n_start = 0, n_stop = 0, n_busy = 0, n_low = 0;

  always @(negedge clk) begin
    if (wr_strobe_o === 1'b1) mon_q.push_back({wr_addr_o, wr_data_o});
    if (start_det_o === 1'b1) n_start++;
    if (stop_det_o === 1'b1) n_stop++;
    if (busy_o === 1'b1) n_busy++;
    if (sda_o === 1'b0) n_low++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_cycle(input logic drv, output logic smp);
    repeat (Q) tick();
    sda_m = drv;
    repeat (H - Q) tick();
    scl_m = 1'b1;
    repeat (H / 2) tick();
    smp = sda_bus;
    repeat (H - H / 2) tick();
    scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    repeat (Q) tick();
    sda_m = 1'b1;
    repeat (H - Q) tick();
    scl_m = 1'b1;
    repeat (H) tick();
    sda_m = 1'b0;
    repeat (H) tick();
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    repeat (Q) tick();
    sda_m = 1'b0;
    repeat (H - Q) tick();
    scl_m = 1'b1;
    repeat (H) tick();
    sda_m = 1'b1;
    repeat (H) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic d;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], d);
    bit_cycle(1'b1, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    logic d;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, d);
      b[i] = d;
    end
    bit_cycle(mack, d);
  endtask

  // Pointer-then-data write; the model commits each byte at the running pointer.
  task automatic wr_txn(input logic [6:0] a, input logic [7:0] p, input int n,
                        input logic do_stop, output int nacks);
    logic ack;
    nacks = 0;
    i2c_start();
    send_byte({a, 1'b0}, ack);
    nacks += int'(ack);
    send_byte(p, ack);
    nacks += int'(ack);
    if (a == SLV) ptr_m = int'(p);
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], ack);
      nacks += int'(ack);
      if (a == SLV) begin
        exp_q.push_back({8'(ptr_m), wbuf[i]});
        mem_m[ptr_m] = wbuf[i];
        ptr_m = (ptr_m + 1) % 256;
      end
    end
    if (do_stop) i2c_stop();
  endtask

  // Auto-incrementing read from the persistent pointer, ACK all but the last byte.
  task automatic rd_txn(input string tag, input int n, input logic do_stop);
    logic ack;
    logic [7:0] b;
    logic [7:0] e;
    i2c_start();
    send_byte({SLV, 1'b1}, ack);
    chk({tag, "_addr_ack"}, 32'(ack), 32'(0));
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, b);
      e = mem_m[ptr_m];
      ptr_m = (ptr_m + 1) % 256;
      chk($sformatf("%s_rd%0d", tag, i), 32'(b), 32'(e));
    end
    repeat (6) tick();
    chk({tag, "_sda_rel"}, 32'(sda_o), 32'(1));
    chk({tag, "_busy_nack"}, 32'(busy_o), 32'(0));
    if (do_stop) i2c_stop();
  endtask

  task automatic check_commits(input string tag);
    logic [15:0] o;
    logic [15:0] e;
    chk({tag, "_ncommit"}, 32'(mon_q.size()), 32'(exp_q.size()));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (mon_q.size() > 0) ? mon_q.pop_front() : 16'hxxxx;
      chk($sformatf("%s_commit%0d", tag, i), 32'(o), 32'(e));
    end
    mon_q.delete();
  endtask

  initial begin
    int nacks, s0, p0, b0, l0, q0, n;
    logic [7:0] p;
    logic d;
    rst = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    repeat (5) tick();
    chk("rst_sda_o", 32'(sda_o), 32'(1));
    chk("rst_busy", 32'(busy_o), 32'(0));
    chk("rst_strobe", 32'(wr_strobe_o), 32'(0));
    chk("rst_wr_addr", 32'(wr_addr_o), 32'(0));
    chk("rst_wr_data", 32'(wr_data_o), 32'(0));
    chk("rst_pulses", 32'({start_det_o, stop_det_o}), 32'(0));
    rst = 1'b0;
    repeat (5) tick();

    // Single-cycle SDA spike while the bus idles high
    s0 = n_start;
    sda_m = 1'b0;
    tick();
    sda_m = 1'b1;
    repeat (12) tick();
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    chk("spike_start", 32'(n_start - s0), 32'(0));
`else
    chk("spike_start", 32'(n_start - s0), 32'(1));
`endif
    repeat (5) tick();

    // Basic write of two bytes at 0x10
    s0 = n_start;
    p0 = n_stop;
    wbuf[0] = 8'hA5;
    wbuf[1] = 8'h5A;
    wr_txn(SLV, 8'h10, 2, 1'b0, nacks);
    chk("w1_nacks", 32'(nacks), 32'(0));
    chk("w1_busy", 32'(busy_o), 32'(1));
    i2c_stop();
    repeat (4) tick();
    chk("w1_busy_after_stop", 32'(busy_o), 32'(0));
    chk("w1_start_cnt", 32'(n_start - s0), 32'(1));
    chk("w1_stop_cnt", 32'(n_stop - p0), 32'(1));
    check_commits("w1");

    // Set pointer, repeated START, read two bytes
    wr_txn(SLV, 8'h10, 0, 1'b0, nacks);
    chk("r1_ptr_nacks", 32'(nacks), 32'(0));
    rd_txn("r1", 2, 1'b1);

    // Pointer persists across STOP
    wbuf[0] = 8'h3C;
    wr_txn(SLV, 8'h0F, 1, 1'b1, nacks);
    chk("w2_nacks", 32'(nacks), 32'(0));
    check_commits("w2");
    rd_txn("r2", 2, 1'b1);

    // Wrong address: no ACK, no drive, no commit, never busy
    b0 = n_busy;
    l0 = n_low;
    wbuf[0] = 8'h77;
    wbuf[1] = 8'h88;
    wr_txn(7'h23, 8'h40, 2, 1'b1, nacks);
    repeat (4) tick();
    chk("bad_nacks", 32'(nacks), 32'(4));
    chk("bad_busy_cycles", 32'(n_busy - b0), 32'(0));
    chk("bad_sda_low_cycles", 32'(n_low - l0), 32'(0));
    check_commits("bad");

    // Pointer wraps from 0xFF to 0x00
    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    wr_txn(SLV, 8'hFF, 2, 1'b1, nacks);
    chk("wrap_nacks", 32'(nacks), 32'(0));
    check_commits("wrap");
    wr_txn(SLV, 8'hFF, 0, 1'b0, nacks);
    rd_txn("wrap_rd", 2, 1'b1);

    // Randomized write bursts read back through the model
    for (int t = 0; t < 4; t++) begin
      p = 8'($urandom_range(0, 255));
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      wr_txn(SLV, p, n, 1'b1, nacks);
      chk($sformatf("rnd%0d_nacks", t), 32'(nacks), 32'(0));
      check_commits($sformatf("rnd%0d", t));
      wr_txn(SLV, p, 0, 1'b0, nacks);
      rd_txn($sformatf("rnd%0d_rd", t), n, 1'b1);
    end

    // Reset in the middle of a data byte
    q0 = mon_q.size();
    i2c_start();
    send_byte({SLV, 1'b0}, d);
    send_byte(8'h30, d);
    bit_cycle(1'b1, d);
    bit_cycle(1'b1, d);
    bit_cycle(1'b0, d);
    bit_cycle(1'b0, d);
    rst = 1'b1;
    tick();
    chk("midrst_sda_o", 32'(sda_o), 32'(1));
    chk("midrst_busy", 32'(busy_o), 32'(0));
    chk("midrst_wr_addr", 32'(wr_addr_o), 32'(0));
    chk("midrst_wr_data", 32'(wr_data_o), 32'(0));
    rst = 1'b0;
    ptr_m = 0;
    repeat (6) tick();
    chk("midrst_no_commit", 32'(mon_q.size()), 32'(q0));
    rd_txn("midrst_ptr0", 1, 1'b1);
    wbuf[0] = 8'h99;
    wr_txn(SLV, 8'h30, 1, 1'b1, nacks);
    chk("postrst_nacks", 32'(nacks), 32'(0));
    check_commits("postrst");

    repeat (10) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
